bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter that turns an unsigned binary count into the three decimal digits (hundreds, tens, ones) consumed by the three-digit seven-segment display decoder. It uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock. Conversion is started by a one-cycle request and finished with a one-cycle done pulse. Results are registered and held stable between conversions, so the display decoder can be wired directly to the digit outputs.

## Interface

Parameters:
- `W`, default 10: width of the binary input. Legal range is 4..10; elaboration fails outside this range.

Ports:
- `i_clk`, input, 1: the single clock. All logic is on its rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_start`, input, 1: conversion request. Sampled only while `o_busy`=0.
- `i_bin`, input, W: unsigned value to convert. Captured on the accepting edge.
- `o_busy`, output, 1: high while a conversion is in progress.
- `o_done`, output, 1: one-cycle pulse when new digits are valid.
- `o_hundreds`, output, 4: BCD hundreds digit, range 0..9.
- `o_tens`, output, 4: BCD tens digit, range 0..9.
- `o_ones`, output, 4: BCD ones digit, range 0..9.
- `o_ovf`, output, 1: the last converted value exceeded 999.

## Operation

- The FSM has two states, IDLE and CONV.
- Internal registers:
  - W-bit shift register `bin_sr`.
  - 16-bit BCD scratch holding four nibbles (thousands, hundreds, tens, ones).
  - Bit counter `cnt`, width ceil(log2(W+1)).
- IDLE with `i_start`=1 at an edge:
  - `bin_sr` is loaded with `i_bin` and the scratch is cleared to 0.
  - `cnt` is set to W, the state moves to CONV and `o_busy` goes to 1.
- CONV, on each edge:
  - Every scratch nibble that is 5 or more has 3 added to it. This uses 4-bit arithmetic and never carries between nibbles.
  - The scratch and `bin_sr` then shift left together by one bit as a combined register. The MSB of `bin_sr` enters scratch bit 0.
  - `cnt` decrements by 1.
- The CONV edge with `cnt`=1 performs the final step. On that same edge:
  - The digit outputs load from the post-step scratch value.
  - If the thousands nibble is 0: the digits take the hundreds, tens and ones nibbles, and `o_ovf` is 0.
  - If the thousands nibble is nonzero: the digits saturate to 9, 9, 9 and `o_ovf` is 1.
  - `o_done` goes to 1, `o_busy` goes to 0 and the state returns to IDLE.
- `o_done` clears on the next edge unless another conversion completes on that edge.
- While `o_busy`=1, `i_start` is ignored and the request is lost. It is not queued.
- Changes on `i_bin` after the accepting edge have no effect.
- Digit outputs and `o_ovf` change only on a done edge and hold their values otherwise.
- For W≤9 the input can never exceed 511, so `o_ovf` is always 0.

## Timing

- Reset (asynchronous assert, synchronous release):
  - State IDLE; `o_busy`=0, `o_done`=0, `o_ovf`=0.
  - All digits are 0, and the scratch, `bin_sr` and `cnt` are 0.
- Latency: with `i_start` accepted at edge E0, `o_done`=1 is visible for exactly the cycle after edge E0+W, and the digits are valid from that same cycle.
- `o_busy` is high for exactly W cycles (from E0 to E0+W).
- `o_busy` and `o_done` are never both 1.
- Back-to-back operation:
  - `i_start` is accepted during the `o_done` cycle, because `o_busy`=0 there.
  - Sustained throughput is one conversion per W+1 cycles.
  - The previous digits stay valid until the next done edge.
- Reset asserted mid-conversion:
  - The conversion aborts immediately, with no `o_done` pulse.
  - All outputs go to their reset values.
  - After release the block is in IDLE and accepts `i_start` on the first edge.
- `i_start` held high continuously produces a new conversion every W+1 cycles, each using the `i_bin` value present on its accepting edge.

## Test plan

All scenarios use W=10.

- **Zero input:** reset, then `i_bin`=0 with a one-cycle `i_start`. Required: `o_busy` high for 10 cycles, then `o_done` for 1 cycle, digits 0/0/0, `o_ovf`=0.
- **Single-digit boundaries:** `i_bin`=9 gives 0/0/9, then `i_bin`=10 gives 0/1/0, then `i_bin`=255 gives 2/5/5. Each value must be exactly correct in its `o_done` cycle.
- **Max and overflow:** `i_bin`=999 gives 9/9/9 with `o_ovf`=0. Then `i_bin`=1000 gives 9/9/9 with `o_ovf`=1, and `i_bin`=1023 gives 9/9/9 with `o_ovf`=1. A following conversion of 5 gives 0/0/5 with `o_ovf`=0.
- **Busy rejection:**
  - Start a conversion of 123.
  - Pulse `i_start` with `i_bin`=456 on the 3rd busy cycle; required result is a single `o_done` with 1/2/3.
  - Drive `i_bin` with random values during busy; the result must still be 1/2/3.
- **Back-to-back:** start a conversion of 321, then assert `i_start` with `i_bin`=654 in the `o_done` cycle. Required: 3/2/1 is held for 11 cycles, then `o_done` again with 6/5/4.
- **Reset mid-operation:** start a conversion of 777 and assert `i_rst_n`=0 for 1 cycle after 5 busy cycles. Required: outputs are immediately 0, with no `o_done`. After release, a conversion of 42 gives 0/4/2 after 10 busy cycles.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one input bit per clock. A one-cycle i_start in IDLE loads the value; W
// clocks later the three registered BCD digits update and o_done pulses for
// one cycle. Values above 999 saturate the digits to 9/9/9 and set o_ovf.
//
// Ports:
//   i_clk       - clock, all logic on the rising edge
//   i_rst_n     - asynchronous active-low reset
//   i_start     - conversion request, sampled only while o_busy = 0
//   i_bin       - unsigned value to convert, captured on the accepting edge
//   o_busy      - high while a conversion is in progress (W cycles)
//   o_done      - one-cycle pulse when new digits are valid
//   o_hundreds  - BCD hundreds digit
//   o_tens      - BCD tens digit
//   o_ones      - BCD ones digit
//   o_ovf       - the last converted value exceeded 999
// -----------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int W = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_bin,
  output logic         o_busy,
  output logic         o_done,
  output logic [3:0]   o_hundreds,
  output logic [3:0]   o_tens,
  output logic [3:0]   o_ones,
  output logic         o_ovf
);

  localparam int CW = $clog2(W + 1);

  generate
    if (W < 4 || W > 10) begin : g_bad_width
      $error("bin_to_bcd_seq: W must be in 4..10");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   bin_sr;
  logic [15:0]    scratch;    // {thousands, hundreds, tens, ones}
  logic [CW-1:0]  cnt;

  logic [15:0]    scratch_adj;
  logic [15:0]    scratch_nxt;

  // Add 3 to any nibble that is 5 or more; 4-bit arithmetic, no inter-nibble
  // carry (an adjusted nibble is at most 12, so it never overflows anyway).
  function automatic logic [3:0] dabble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // NOTE: every signal written here gets a value on every path, so this stays
  // pure combinational logic and no latch is inferred.
  always_comb begin
    scratch_adj = '0;
    for (int i = 0; i < 4; i++) begin
      scratch_adj[i*4 +: 4] = dabble(scratch[i*4 +: 4]);
    end
    // Combined {scratch, bin_sr} shift: MSB of bin_sr enters scratch bit 0.
    scratch_nxt = {scratch_adj[14:0], bin_sr[W-1]};
  end

  // NOTE: state registers use non-blocking assignments so every register sees
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      bin_sr     <= '0;
      scratch    <= '0;
      cnt        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_hundreds <= 4'd0;
      o_tens     <= 4'd0;
      o_ones     <= 4'd0;
      o_ovf      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            bin_sr  <= i_bin;
            scratch <= '0;
            cnt     <= CW'(W);
            o_busy  <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= scratch_nxt;
          bin_sr  <= {bin_sr[W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            // Final step: publish the post-step scratch, saturating above 999.
            if (scratch_nxt[15:12] == 4'd0) begin
              o_hundreds <= scratch_nxt[11:8];
              o_tens     <= scratch_nxt[7:4];
              o_ones     <= scratch_nxt[3:0];
              o_ovf      <= 1'b0;
            end else begin
              o_hundreds <= 4'd9;
              o_tens     <= 4'd9;
              o_ones     <= 4'd9;
              o_ovf      <= 1'b1;
            end
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq with W = 10. Expected digits come
// from plain decimal arithmetic (/ and %) with saturation above 999. Inputs
// are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int W = 10;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_start;
  logic [W-1:0] i_bin;
  logic         o_busy;
  logic         o_done;
  logic [3:0]   o_hundreds;
  logic [3:0]   o_tens;
  logic [3:0]   o_ones;
  logic         o_ovf;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Currently held result {ovf, hundreds, tens, ones} expected on the outputs.
  logic [12:0] held;

  bin_to_bcd_seq #(.W(W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_hundreds (o_hundreds),
    .o_tens     (o_tens),
    .o_ones     (o_ones),
    .o_ovf      (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] model(input int v);
    if (v > 999) return {1'b1, 4'd9, 4'd9, 4'd9};
    return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [12:0] outs();
    return {o_ovf, o_hundreds, o_tens, o_ones};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Start a conversion of v now (taken on the next edge), track the W busy
  // cycles and return at the sample point of the o_done cycle. Optionally
  // scramble i_bin during busy and/or pulse i_start at busy cycle inject_k.
  task automatic run_conv(input int v, input bit jitter, input int inject_k);
    i_bin   = W'(v);
    i_start = 1'b1;
    step();
    for (int k = 0; k < W; k++) begin
      check("busy_high", 32'(o_busy), 32'd1);
      check("done_low_in_busy", 32'(o_done), 32'd0);
      check("digits_held_in_busy", 32'(outs()), 32'(held));
      if (jitter) i_bin = W'($urandom);
      if (k == inject_k) begin
        i_start = 1'b1;
        i_bin   = W'(456);
      end else begin
        i_start = 1'b0;
      end
      step();
    end
    i_start = 1'b0;
    held = model(v);
    check("busy_low_at_done", 32'(o_busy), 32'd0);
    check("done_pulse", 32'(o_done), 32'd1);
    check($sformatf("digits_%0d", v), 32'(outs()), 32'(held));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check("done_clears", 32'(o_done), 32'd0);
      check("busy_idle", 32'(o_busy), 32'd0);
      check("digits_hold_idle", 32'(outs()), 32'(held));
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    held    = '0;
    #1;
    check("reset_outputs", 32'({o_busy, o_done, outs()}), 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    idle_cycles(1);

    // Zero and single-digit boundaries.
    run_conv(0, 1'b0, -1);    idle_cycles(2);
    run_conv(9, 1'b0, -1);    idle_cycles(1);
    run_conv(10, 1'b0, -1);   idle_cycles(1);
    run_conv(255, 1'b0, -1);  idle_cycles(1);

    // Maximum and overflow saturation.
    run_conv(999, 1'b0, -1);  idle_cycles(1);
    run_conv(1000, 1'b0, -1); idle_cycles(1);
    run_conv(1023, 1'b0, -1); idle_cycles(1);
    run_conv(5, 1'b0, -1);    idle_cycles(1);

    // Busy rejection: start pulse on the 3rd busy cycle, then i_bin jitter.
    run_conv(123, 1'b0, 2);   idle_cycles(12);
    run_conv(123, 1'b1, -1);  idle_cycles(2);

    // Back-to-back: second start issued in the o_done cycle.
    run_conv(321, 1'b0, -1);
    run_conv(654, 1'b0, -1);  idle_cycles(1);

    // Reset mid-conversion.
    i_bin   = W'(777);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("busy_before_abort", 32'(o_busy), 32'd1);
      step();
    end
    i_rst_n = 1'b0;
    #1;
    check("abort_outputs_zero", 32'({o_busy, o_done, outs()}), 32'd0);
    step();
    check("abort_no_done", 32'({o_busy, o_done, outs()}), 32'd0);
    i_rst_n = 1'b1;
    held = '0;
    run_conv(42, 1'b0, -1);   idle_cycles(1);

    // Randomized conversions, mixing back-to-back and gapped starts.
    for (int r = 0; r < 40; r++) begin
      run_conv(int'($urandom_range(0, 1023)), 1'($urandom), -1);
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    n_miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $fatal(1, "timeout");
  end

endmodule
